// File: rtl/led128_io_sequencer.sv
// LED-128 host I/O sequencer: latches masked shares, sequences core reset/run, returns ciphertext shares.
// Optional RUN-state watchdog enabled by defining LED128_IO_WATCHDOG_EN.
module led128_io_sequencer #(
  parameter int NUM_SHARES   = 3,
  parameter int BLOCK_W      = 64,
  parameter int KEY_W        = 128,
  parameter int RST_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_SHARES*BLOCK_W-1:0] pt_shares,
  input  logic [NUM_SHARES*KEY_W-1:0]   key_shares,
  output logic                          core_rst,
  output logic [NUM_SHARES*BLOCK_W-1:0] core_pt,
  output logic [NUM_SHARES*KEY_W-1:0]   core_key,
  input  logic                          core_done,
  input  logic [NUM_SHARES*BLOCK_W-1:0] core_ct,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_SHARES*BLOCK_W-1:0] ct_shares,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES);

  logic [1:0] state;
  logic [3:0] rst_cnt;

  // Gated by rst so the host never sees acceptance while the sequencer is held in reset.
  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);

`ifdef LED128_IO_WATCHDOG_EN
  localparam logic [9:0] TIMEOUT_LAST = 10'(DONE_TIMEOUT - 1);
  logic [9:0] run_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      core_rst  <= 1'b1;
      out_valid <= 1'b0;
      core_pt   <= '0;
      core_key  <= '0;
      ct_shares <= '0;
`ifdef LED128_IO_WATCHDOG_EN
      run_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            core_pt  <= pt_shares;
            core_key <= key_shares;
            rst_cnt  <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          // core_rst releases 1+RST_CYCLES cycles after the accept edge.
          if (rst_cnt == RST_LAST) begin
            core_rst <= 1'b0;
            state    <= S_RUN;
`ifdef LED128_IO_WATCHDOG_EN
            run_cnt  <= '0;
`endif
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        S_RUN: begin
          // Only the first cycle of the done train is captured; the rest land in OUT/IDLE.
          if (core_done) begin
            ct_shares <= core_ct;
            out_valid <= 1'b1;
            core_rst  <= 1'b1;
            state     <= S_OUT;
          end
`ifdef LED128_IO_WATCHDOG_EN
          else if (run_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            core_rst    <= 1'b1;
            state       <= S_IDLE;
          end else begin
            run_cnt <= run_cnt + 10'd1;
          end
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          core_rst  <= 1'b1;
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led128_io_sequencer.sv
// Self-checking bench for led128_io_sequencer; watchdog scenarios run when LED128_IO_WATCHDOG_EN is defined.
module tb_led128_io_sequencer;
  localparam int NS  = 3;
  localparam int BW  = 64;
  localparam int KW  = 128;
  localparam int RC  = 2;
  localparam int TO  = 16;
  localparam int PW  = NS * BW;
  localparam int KKW = NS * KW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [PW-1:0]  pt_shares = '0;
  logic [KKW-1:0] key_shares = '0;
  logic           core_rst;
  logic [PW-1:0]  core_pt;
  logic [KKW-1:0] core_key;
  logic           core_done = 1'b0;
  logic [PW-1:0]  core_ct = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PW-1:0]  ct_shares;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  led128_io_sequencer #(
    .NUM_SHARES(NS), .BLOCK_W(BW), .KEY_W(KW), .RST_CYCLES(RC), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pt_shares(pt_shares), .key_shares(key_shares), .core_rst(core_rst),
    .core_pt(core_pt), .core_key(core_key), .core_done(core_done), .core_ct(core_ct),
    .out_valid(out_valid), .out_ready(out_ready), .ct_shares(ct_shares),
    .busy(busy), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_v;
  logic [PW-1:0] held_ct;
  logic          held_vld = 1'b0;
  logic          ov_prev = 1'b0;
  int            ov_rises = 0;

  // Scoreboard monitor: compares on each output handshake, tracks out_valid rises and back-pressure stability.
  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (out_valid === 1'b1 && ov_prev !== 1'b1) ov_rises++;
      if (held_vld && out_valid === 1'b1) begin
        checks++;
        if (ct_shares !== held_ct) begin
          errors++;
          $display("FAIL ct_stable: got %h expected %h", ct_shares, held_ct);
        end
      end
      held_vld = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_ct  = ct_shares;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got ct %h expected no output", ct_shares);
        end else begin
          exp_v = exp_q.pop_front();
          if (ct_shares !== exp_v) begin
            errors++;
            $display("FAIL ct_shares: got %h expected %h", ct_shares, exp_v);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [PW-1:0] pt, input logic [KKW-1:0] key);
    int n;
    pt_shares  = pt;
    key_shares = key;
    in_valid   = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: got in_ready %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL after_accept: got in_ready %b busy %b expected 0 1", in_ready, busy);
    end
    checks++;
    if (core_pt !== pt || core_key !== key) begin
      errors++;
      $display("FAIL core_shares: got pt %h expected %h", core_pt, pt);
    end
  endtask

  // Called right after accept: core_rst must stay high through START and fall 1+RC edges after accept.
  task automatic enter_run();
    for (int i = 0; i <= RC; i++) begin
      checks++;
      if (core_rst !== 1'b1) begin
        errors++;
        $display("FAIL core_rst_start: cycle %0d got %b expected 1", i, core_rst);
      end
      tick();
    end
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL core_rst_run: got %b expected 0", core_rst);
    end
  endtask

  task automatic done_train(input logic [PW-1:0] base, input bit vary, input bit ready);
    out_ready = ready;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_valid_pre_done: got %b expected 0", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      core_done = 1'b1;
      core_ct   = vary ? (base + PW'(i * 7 + 1) - PW'(1)) : base;
      if (i == 0) exp_q.push_back(base);
      tick();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1 || ct_shares !== base) begin
          errors++;
          $display("FAIL out_valid_first_done: got %b ct %h expected 1 ct %h", out_valid, ct_shares, base);
        end
      end
      if (ready && i == 1) begin
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_handshake: got busy %b out_valid %b expected 0 0", busy, out_valid);
        end
      end
    end
    core_done = 1'b0;
    core_ct   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || core_rst !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got in_ready %b core_rst %b out_valid %b busy %b timeout_err %b expected 0 1 0 0 0",
               in_ready, core_rst, out_valid, busy, timeout_err);
    end
    checks++;
    if (ct_shares !== '0 || core_pt !== '0 || core_key !== '0) begin
      errors++;
      $display("FAIL reset_data: got ct %h pt %h expected zero", ct_shares, core_pt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got in_ready %b core_rst %b expected 1 1", in_ready, core_rst);
    end
  endtask

  task automatic test_single();
    int r0;
    r0 = ov_rises;
    accept({NS{64'h1111_2222_3333_4444}}, {KKW/64{64'hA5A5_5A5A_0F0F_F0F0}});
    enter_run();
    repeat (300) tick();
    done_train({NS{64'h0123_4567_89AB_CDEF}}, 1'b0, 1'b1);
    tick();
    checks++;
    if (ov_rises - r0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_summary: got rises %0d pending %0d busy %b expected 1 0 0", ov_rises - r0, exp_q.size(), busy);
    end
  endtask

  task automatic test_done_train();
    int r0;
    r0 = ov_rises;
    accept({NS{64'hDEAD_BEEF_0000_0001}}, {KKW/64{64'h0102_0304_0506_0708}});
    enter_run();
    repeat (17) tick();
    done_train({NS{64'hCAFE_F00D_1234_0000}}, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || ct_shares !== {NS{64'hCAFE_F00D_1234_0000}}) begin
      errors++;
      $display("FAIL train_first_value: got %b ct %h expected 1 first value", out_valid, ct_shares);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (ov_rises - r0 != 1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL train_one_output: got rises %0d out_valid %b expected 1 0", ov_rises - r0, out_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] pt_a, pt_b;
    pt_a = {NS{64'h0A0A_0A0A_0A0A_0A0A}};
    pt_b = {NS{64'h0B0B_0B0B_0B0B_0B0B}};
    accept(pt_a, {KKW/64{64'h1234_5678_9ABC_DEF0}});
    enter_run();
    repeat (10) tick();
    pt_shares = pt_b;
    key_shares = {KKW/64{64'h0FED_CBA9_8765_4321}};
    in_valid = 1'b1;
    done_train({NS{64'h5555_AAAA_5555_AAAA}}, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (in_ready !== 1'b0 || core_pt !== pt_a) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got in_ready %b core_pt %h expected 0 %h", i, in_ready, core_pt, pt_a);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake_cycle: got in_ready %b expected 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_handshake: got in_ready %b expected 1", in_ready);
    end
    accept(pt_b, {KKW/64{64'h0FED_CBA9_8765_4321}});
    enter_run();
    repeat (20) tick();
    done_train({NS{64'h7777_8888_9999_0000}}, 1'b0, 1'b1);
    tick();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_block: got pending %0d busy %b expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_mid_run_reset();
    int r0;
    accept({NS{64'h3333_3333_3333_3333}}, {KKW/64{64'h4444_4444_4444_4444}});
    enter_run();
    repeat (49) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: got busy %b core_rst %b out_valid %b in_ready %b expected 0 1 0 1",
               busy, core_rst, out_valid, in_ready);
    end
    checks++;
    if (core_pt !== '0 || ct_shares !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got pt %h ct %h expected zero", core_pt, ct_shares);
    end
    r0 = ov_rises;
    repeat (3) tick();
    core_done = 1'b1;
    core_ct = {NS{64'hBAD0_BAD0_BAD0_BAD0}};
    repeat (5) tick();
    core_done = 1'b0;
    tick();
    checks++;
    if (ov_rises != r0 || busy !== 1'b0 || ct_shares !== '0) begin
      errors++;
      $display("FAIL late_done_ignored: got rises %0d busy %b ct %h expected %0d 0 zero", ov_rises, busy, ct_shares, r0);
    end
  endtask

`ifdef LED128_IO_WATCHDOG_EN
  task automatic test_watchdog();
    int r0;
    r0 = ov_rises;
    accept({NS{64'h6666_0000_6666_0000}}, {KKW/64{64'h7777_0000_7777_0000}});
    enter_run();
    repeat (TO - 1) tick();
    checks++;
    if (timeout_err !== 1'b0 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: got timeout_err %b core_rst %b expected 0 0", timeout_err, core_rst);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || ct_shares !== '0) begin
      errors++;
      $display("FAIL wd_abort: got timeout_err %b core_rst %b busy %b out_valid %b expected 1 1 0 0",
               timeout_err, core_rst, busy, out_valid);
    end
    tick();
    checks++;
    if (ov_rises != r0) begin
      errors++;
      $display("FAIL wd_no_output: got rises %0d expected %0d", ov_rises, r0);
    end
    accept({NS{64'h1212_3434_5656_7878}}, {KKW/64{64'h9A9A_BCBC_DEDE_F0F0}});
    enter_run();
    repeat (5) tick();
    done_train({NS{64'hABCD_EF01_2345_6789}}, 1'b0, 1'b1);
    tick();
    checks++;
    if (timeout_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wd_sticky: got timeout_err %b pending %0d expected 1 0", timeout_err, exp_q.size());
    end
  endtask

  task automatic test_watchdog_boundary();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    accept({NS{64'h0F0F_1E1E_2D2D_3C3C}}, {KKW/64{64'h4B4B_5A5A_6969_7878}});
    enter_run();
    repeat (TO - 1) tick();
    done_train({NS{64'hFEDC_BA98_7654_3210}}, 1'b0, 1'b1);
    tick();
    checks++;
    if (timeout_err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wd_boundary: got timeout_err %b pending %0d expected 0 0", timeout_err, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_done_train();
    test_back_pressure();
    test_mid_run_reset();
`ifdef LED128_IO_WATCHDOG_EN
    test_watchdog();
    test_watchdog_boundary();
`else
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_tied: got %b expected 0", timeout_err);
    end
`endif
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
